// File: rtl/edge_capture_encoder.sv
// rtl/edge_capture_encoder.sv - rising-edge capture with round-robin 8-to-3 encoder and one-slot output
module edge_capture_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] D,
  input  logic       ready,
  output logic [2:0] Y,
  output logic       valid,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_d_q;
  logic [7:0] r_pending;
  logic [2:0] r_y;
  logic [2:0] r_ptr;
  logic       r_overflow;

  logic [7:0] w_edge;
  logic [7:0] w_clear;
  logic [7:0] w_pending_nxt;
  logic [2:0] w_grant;
  logic [2:0] w_idx;
  logic       w_any;
  logic       w_load;
  logic       w_merge;

  // New events are rising edges against the previous cycle's sample
  assign w_edge = D & ~r_d_q;
  assign w_any  = |r_pending;

  // Slot accepts a new code when empty or when its current code leaves this cycle
  assign w_load = w_any && ((r_state == S_EMPTY) || ready);

  // Round-robin search from r_ptr upward; iterating downward lets the nearest set bit win
  always_comb begin
    w_grant = r_ptr;
    w_idx   = r_ptr;
    for (int k = 7; k >= 0; k--) begin
      w_idx = r_ptr + 3'(k);
      if (r_pending[w_idx]) begin
        w_grant = w_idx;
      end
    end
  end

  // A new edge on the bit being granted re-sets it, so set wins over clear
  assign w_clear       = w_load ? (8'b1 << w_grant) : 8'h00;
  assign w_pending_nxt = (r_pending & ~w_clear) | w_edge;
  assign w_merge       = |(w_edge & r_pending & ~w_clear);

  // Input sampling, pending event set and sticky overflow
  always_ff @(posedge clk) begin
    r_d_q <= D;
    if (rst) begin
      r_pending  <= 8'h00;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_merge) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Output slot state machine with registered code and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_y     <= 3'b000;
      r_ptr   <= 3'b000;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_load) begin
            r_y     <= w_grant;
            r_ptr   <= w_grant + 3'd1;
            r_state <= S_FULL;
          end
        end
        S_FULL: begin
          if (w_load) begin
            r_y     <= w_grant;
            r_ptr   <= w_grant + 3'd1;
            r_state <= S_FULL;
          end else if (ready) begin
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign Y        = r_y;
  assign valid    = (r_state == S_FULL);
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_edge_capture_encoder.sv
// tb/tb_edge_capture_encoder.sv - scoreboard bench for edge_capture_encoder
module tb_edge_capture_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] D;
  logic       ready;
  logic [2:0] Y;
  logic       valid;
  logic [7:0] pending;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit [7:0] m_prev;
  bit [7:0] m_pend;
  int       m_ptr;
  bit       m_full;
  bit       m_ovf;
  int       exp_q[$];

  edge_capture_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .D        (D),
    .ready    (ready),
    .Y        (Y),
    .valid    (valid),
    .pending  (pending),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Events wait in a set; the slot holds one code; grants rotate from the last winner
  task automatic model(input bit [7:0] d, input bit r, input bit rs);
    bit [7:0] old;
    int g;
    if (rs) begin
      m_prev = d;
      m_pend = '0;
      m_ptr  = 0;
      m_full = 0;
      m_ovf  = 0;
      exp_q.delete();
      return;
    end
    old = m_pend;
    g   = -1;
    if ((!m_full || r) && old != 0) begin
      for (int k = 0; k < 8; k++) begin
        if (g < 0 && old[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
      end
    end
    if (g >= 0) begin
      exp_q.push_back(g);
      m_full    = 1;
      m_ptr     = (g + 1) % 8;
      m_pend[g] = 0;
    end else if (m_full && r) begin
      m_full = 0;
    end
    for (int i = 0; i < 8; i++) begin
      if (d[i] && !m_prev[i]) begin
        if (old[i] && i != g) m_ovf = 1;
        m_pend[i] = 1;
      end
    end
    m_prev = d;
  endtask

  // Apply inputs for one edge, advance the model, then compare state
  task automatic step(input bit [7:0] d, input bit r, input bit rs);
    D     = d;
    ready = r;
    rst   = rs;
    @(posedge clk);
    model(d, r, rs);
    #1;
    check("pending", int'(pending), int'(m_pend));
    check("overflow", int'(overflow), int'(m_ovf));
    check("valid", int'(valid), int'(m_full));
  endtask

  // Monitor: every presented code must match the oldest expected code; pop on handshake
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("queue_nonempty", 0, 1);
      end else begin
        check("Y", int'(Y), exp_q[0]);
        if (ready === 1'b1 && rst === 1'b0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    D     = 8'h01;
    ready = 1'b1;
    rst   = 1'b1;

    // level held through reset produces no event
    step(8'h01, 1, 1);
    step(8'h01, 1, 1);
    check("rst_valid", int'(valid), 0);
    check("rst_pending", int'(pending), 0);
    for (int i = 0; i < 3; i++) step(8'h01, 1, 0);
    check("held_pending", int'(pending), 0);
    check("held_overflow", int'(overflow), 0);

    // single pulse on D3
    step(8'h08, 1, 0);
    check("d3_pending", int'(pending), 8'h08);
    step(8'h00, 1, 0);
    check("d3_valid", int'(valid), 1);
    check("d3_code", int'(Y), 3);
    step(8'h00, 1, 0);
    check("d3_one_cycle", int'(valid), 0);

    // three simultaneous edges after reset
    step(8'h00, 1, 1);
    step(8'h00, 1, 0);
    step(8'hA2, 1, 0);
    for (int i = 0; i < 5; i++) step(8'h00, 1, 0);

    // backpressure with two pulses
    step(8'h00, 0, 0);
    step(8'h04, 0, 0);
    step(8'h00, 0, 0);
    step(8'h40, 0, 0);
    step(8'h00, 0, 0);
    check("bp_code", int'(Y), 2);
    check("bp_pending", int'(pending), 8'h40);
    for (int i = 0; i < 4; i++) step(8'h00, 1, 0);

    // round-robin after a grant of 5
    step(8'h20, 1, 0);
    step(8'h00, 1, 0);
    step(8'h41, 1, 0);
    step(8'h00, 1, 0);
    check("rr_first", int'(Y), 6);
    for (int i = 0; i < 3; i++) step(8'h00, 1, 0);

    // merged events on D4 under backpressure
    for (int p = 0; p < 3; p++) begin
      step(8'h10, 0, 0);
      step(8'h00, 0, 0);
    end
    check("ovf_code", int'(Y), 4);
    check("ovf_pending", int'(pending), 8'h10);
    check("ovf_flag", int'(overflow), 1);
    for (int i = 0; i < 4; i++) step(8'h00, 1, 0);
    check("ovf_sticky", int'(overflow), 1);

    // randomized traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      step(8'($urandom & $urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
    end

    // mid-operation reset discards everything
    step(8'h00, 0, 0);
    step(8'hFF, 0, 0);
    step(8'h00, 0, 0);
    step(8'h00, 0, 1);
    check("midrst_valid", int'(valid), 0);
    check("midrst_pending", int'(pending), 0);

    // drain
    for (int i = 0; i < 12; i++) step(8'h00, 1, 0);
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", int'(valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
